// File: rtl/dfr_internal_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : dfr_internal_core_if
//  Description : Start/busy/done/stall handshake bundle for the DFR compute
//                core. The master drives the request side and the slave
//                (the core) returns status and the readout result.
//  Signals     : start      - request to process i_data/q_data
//                stall      - freeze request from the wrapper
//                i_data     - signed in-phase sample (16 bit)
//                q_data     - signed quadrature sample (16 bit)
//                busy       - sample in flight
//                done       - one-cycle result-valid pulse
//                returndata - signed readout result (26 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dfr_internal_core_if;
   logic               start;
   logic               stall;
   logic signed [15:0] i_data;
   logic signed [15:0] q_data;
   logic               busy;
   logic               done;
   logic signed [25:0] returndata;

   modport master (
      output start, stall, i_data, q_data,
      input  busy, done, returndata
   );

   modport slave (
      input  start, stall, i_data, q_data,
      output busy, done, returndata
   );
endinterface
`default_nettype wire

// File: rtl/dfr_internal_core.sv
`default_nettype none
// ============================================================================
//  Module      : dfr_internal_core
//  Description : Delayed-feedback reservoir core. Each accepted I/Q sample is
//                reduced to u = (i+q)/2 and time-multiplexed through NODES
//                virtual nodes; every node applies a +/-u input mask, leaky
//                feedback from its own previous-sample state and a saturating
//                nonlinearity. A weighted linear readout (weights 1..NODES)
//                yields one 26-bit signed result per sample.
//  Ports       : clock   - sole clock, rising edge
//                resetn  - synchronous active-low reset (overrides stall)
//                clock2x - wrapper compatibility input, unused
//                bus     - slave side of dfr_internal_core_if
//  Revision    : 1.0 - initial release
// ============================================================================
module dfr_internal_core #(
   parameter int               NODES = 16,
   parameter logic [NODES-1:0] MASK  = 16'hF0F0
) (
   input wire logic           clock,
   input wire logic           resetn,
   input wire logic           clock2x,
   dfr_internal_core_if.slave bus
);

   localparam int             c_kw     = (NODES > 1) ? $clog2(NODES) : 1;
   localparam logic [c_kw-1:0] c_last_k = c_kw'(NODES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PROC = 1'b1
   } state_t;

   state_t             r_state;
   logic [c_kw-1:0]    r_k;
   logic signed [15:0] r_u;
   logic signed [25:0] r_acc;
   logic signed [25:0] r_ret;
   logic               r_busy;
   logic               r_done;
   logic signed [15:0] r_dline [NODES];

   // clock2x exists only so the wrapper can connect it.
   wire w_unused_ok = &{1'b0, clock2x};

   // Input reduction: 17-bit sum, arithmetic halve, keep low 16 bits.
   logic signed [16:0] w_u_sum;
   logic signed [15:0] w_u;
   assign w_u_sum = {bus.i_data[15], bus.i_data} + {bus.q_data[15], bus.q_data};
   assign w_u     = w_u_sum[16:1];

   // Node computation. The delay-line tail holds this node's state from the
   // previous sample because the line is exactly NODES long.
   logic signed [15:0] w_tail;
   logic signed [16:0] w_m;
   logic signed [15:0] w_f;
   logic signed [17:0] w_s;
   logic signed [15:0] w_x_new;

   assign w_tail = r_dline[NODES-1];
   assign w_m    = MASK[r_k] ? {r_u[15], r_u} : -{r_u[15], r_u};
   assign w_f    = {w_tail[15], w_tail[15:1]};
   assign w_s    = {w_m[16], w_m} + {{2{w_f[15]}}, w_f};

   always_comb begin
      w_x_new = w_s[15:0];
      if (w_s[17:15] != 3'b000 && w_s[17:15] != 3'b111) begin
         w_x_new = w_s[17] ? 16'sh8000 : 16'sh7FFF;
      end
   end

   // Readout: acc += (k+1) * x_new, all in 26-bit signed arithmetic.
   logic signed [25:0] w_weight;
   logic signed [25:0] w_x_ext;
   logic signed [25:0] w_acc_next;

   assign w_weight   = signed'(26'(r_k) + 26'd1);
   assign w_x_ext    = {{10{w_x_new[15]}}, w_x_new};
   assign w_acc_next = r_acc + (w_x_ext * w_weight);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_u     <= '0;
         r_acc   <= '0;
         r_ret   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < NODES; i++) begin
            r_dline[i] <= '0;
         end
      end else if (!bus.stall) begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_u     <= w_u;
                  r_k     <= '0;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_PROC;
               end
            end
            S_PROC: begin
               r_dline[0] <= w_x_new;
               for (int i = 1; i < NODES; i++) begin
                  r_dline[i] <= r_dline[i-1];
               end
               r_acc <= w_acc_next;
               r_k   <= r_k + c_kw'(1);
               if (r_k == c_last_k) begin
                  r_ret   <= w_acc_next;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.returndata = r_ret;

endmodule
`default_nettype wire

// File: tb/tb_dfr_internal_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dfr_internal_core
//  Description : Directed self-checking bench for dfr_internal_core with
//                hand-computed readout values (reset, first sample, feedback,
//                saturation, stall, reset mid-operation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfr_internal_core;

   logic clock   = 1'b0;
   logic clock2x = 1'b0;
   logic resetn  = 1'b0;

   int chk_cnt = 0;
   int err_cnt = 0;

   dfr_internal_core_if bus ();

   dfr_internal_core #(
      .NODES (16),
      .MASK  (16'hF0F0)
   ) dut (
      .clock   (clock),
      .resetn  (resetn),
      .clock2x (clock2x),
      .bus     (bus)
   );

   always #5    clock   = ~clock;
   always #2.5  clock2x = ~clock2x;

   task automatic check(input string tag, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // start must already be high; next edge is the accept edge.
   task automatic run_sample(input string tag, input int exp_val);
      step(1);
      check({tag, "_busy_after_accept"}, bus.busy, 1);
      check({tag, "_done_after_accept"}, bus.done, 0);
      step(15);
      check({tag, "_done_early"}, bus.done, 0);
      step(1);
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_busy_fall"}, bus.busy, 0);
      check({tag, "_value"}, bus.returndata, exp_val);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(2);
      resetn = 1'b1;
   endtask

   initial begin
      bit seen_done;
      bus.start  = 1'b0;
      bus.stall  = 1'b0;
      bus.i_data = '0;
      bus.q_data = '0;

      // Reset state.
      resetn = 1'b0;
      step(2);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ret", bus.returndata, 0);
      resetn = 1'b1;

      // First sample then back-to-back feedback sample.
      bus.i_data = 16'sd1;
      bus.q_data = 16'sd2;
      bus.start  = 1'b1;
      run_sample("first", 32);
      run_sample("feedback", -20);
      bus.start = 1'b0;
      step(1);
      check("done_pulse_clear", bus.done, 0);
      check("ret_hold", bus.returndata, -20);

      // Saturation from reset.
      do_reset();
      bus.i_data = 16'sd32767;
      bus.q_data = 16'sd32767;
      bus.start  = 1'b1;
      run_sample("sat1", 1048544);
      run_sample("sat2", 1048492);
      bus.start = 1'b0;
      step(1);

      // Stall mid-processing and during done.
      do_reset();
      bus.i_data = 16'sd1;
      bus.q_data = 16'sd2;
      bus.start  = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(5);
      bus.stall = 1'b1;
      step(5);
      check("stall_busy", bus.busy, 1);
      check("stall_done", bus.done, 0);
      bus.stall = 1'b0;
      step(10);
      check("stall_done_early", bus.done, 0);
      step(1);
      check("stall_done", bus.done, 1);
      check("stall_value", bus.returndata, 32);
      bus.stall = 1'b1;
      step(3);
      check("stall_done_held", bus.done, 1);
      check("stall_value_held", bus.returndata, 32);
      bus.stall = 1'b0;
      step(1);
      check("stall_done_release", bus.done, 0);

      // Reset while node 8 is pending: no done, delay line cleared.
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(8);
      check("midrst_busy_before", bus.busy, 1);
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_ret", bus.returndata, 0);
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.done) seen_done = 1'b1;
      end
      check("midrst_no_done", seen_done, 0);
      bus.start = 1'b1;
      run_sample("after_midrst", 32);
      bus.start = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
